fft_bitrev_reorder: RTL



---
 rtl/fft_bitrev_reorder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// fft_bitrev_reorder : ping-pong reorder of a bit-reversed FFT stream into
//                      natural bin order.                      Revision 1.0
// ============================================================================
module fft_bitrev_reorder #(
   parameter  int N     = 1024,
   parameter  int WIDTH = 32,
   localparam int LOG2N = $clog2(N)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             di_en,
   input  logic [WIDTH-1:0] di_re,
   input  logic [WIDTH-1:0] di_im,
   output logic             do_en,
   output logic [WIDTH-1:0] do_re,
   output logic [WIDTH-1:0] do_im,
   output logic [LOG2N-1:0] do_idx,
   output logic             do_last
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      READ = 1'b1
   } state_t;

   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

   logic [2*WIDTH-1:0] mem [2*N];

   logic [LOG2N-1:0]   wcnt;
   logic [LOG2N-1:0]   wcnt_rev;
   logic               wbank;
   logic [1:0]         full;
   logic [1:0]         full_next;

   state_t             state;
   state_t             state_next;
   logic [LOG2N-1:0]   rcnt;
   logic [LOG2N-1:0]   rcnt_next;
   logic               rbank;
   logic               rbank_next;

   logic               wr_last;
   logic               rd_issue;
   logic               rd_done;

   logic [2*WIDTH-1:0] rd_data;
   logic               rd_valid;
   logic               rd_last;
   logic [LOG2N-1:0]   rd_idx;

   generate
      for (genvar b = 0; b < LOG2N; b++) begin : g_bitrev
         assign wcnt_rev[b] = wcnt[LOG2N-1-b];
      end
   endgenerate

   assign wr_last  = di_en && (wcnt == LAST_IDX);
   assign rd_issue = (state == READ);
   assign rd_done  = rd_issue && (rcnt == LAST_IDX);

   // A writer set wins over a reader clear should they ever hit the same bank.
   always_comb begin
      full_next = full;
      if (rd_done) full_next[rbank] = 1'b0;
      if (wr_last) full_next[wbank] = 1'b1;
   end

   always_comb begin
      state_next = state;
      rcnt_next  = rcnt;
      rbank_next = rbank;
      case (state)
         IDLE: begin
            if (full[rbank]) begin
               state_next = READ;
               rcnt_next  = '0;
            end
         end
         READ: begin
            rcnt_next = rcnt + 1'b1;
            if (rcnt == LAST_IDX) begin
               rbank_next = ~rbank;
               // Looking at full_next lets a bank completed on this very edge
               // follow on without a bubble.
               if (!full_next[~rbank]) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wcnt  <= '0;
         wbank <= 1'b0;
         full  <= '0;
         state <= IDLE;
         rcnt  <= '0;
         rbank <= 1'b0;
      end else begin
         if (di_en) begin
            wcnt <= wcnt + 1'b1;
            if (wr_last) wbank <= ~wbank;
         end
         full  <= full_next;
         state <= state_next;
         rcnt  <= rcnt_next;
         rbank <= rbank_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset && di_en) mem[{wbank, wcnt_rev}] <= {di_re, di_im};
      if (rd_issue)       rd_data <= mem[{rbank, rcnt}];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_idx   <= '0;
         do_en    <= 1'b0;
         do_last  <= 1'b0;
         do_re    <= '0;
         do_im    <= '0;
         do_idx   <= '0;
      end else begin
         rd_valid <= rd_issue;
         rd_last  <= rd_done;
         rd_idx   <= rcnt;
         do_en    <= rd_valid;
         do_last  <= rd_valid && rd_last;
         if (rd_valid) begin
            do_re  <= rd_data[2*WIDTH-1:WIDTH];
            do_im  <= rd_data[WIDTH-1:0];
            do_idx <= rd_idx;
         end
      end
   end

   // The bank being released on this edge may already take its first new sample.
   a_no_overwrite : assert property (@(posedge clock) disable iff (!reset)
      !(di_en && full[wbank] && !(rd_done && (rbank == wbank))));

endmodule
`default_nettype wire
